sa_share_arbiter: RTL and testbench

//  Round-robin arbiter that time-shares one SA_wrapper systolic array between NUM_REQ matrix-op requesters.

---
 rtl/sa_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sa_share_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_share_arbiter.sv
// Round-robin arbiter time-sharing one SA_wrapper systolic array between NUM_REQ requesters.
// Define SA_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT cycles).
module sa_share_arbiter #(
  parameter int D_W     = 8,
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                                        I_CLK,
  input  logic                                        I_RST_N,
  input  logic [NUM_REQ-1:0]                          I_REQ,
  input  logic [NUM_REQ-1:0]                          I_REQ_LOCK,
  input  logic [NUM_REQ-1:0]                          I_REQ_ACC,
  input  logic [NUM_REQ-1:0][SA_R-1:0][SA_C-1:0][D_W-1:0] I_REQ_MAT_1,
  input  logic [NUM_REQ-1:0][SA_R-1:0][SA_C-1:0][D_W-1:0] I_REQ_MAT_2,
  output logic [NUM_REQ-1:0]                          O_GNT,
  output logic [NUM_REQ-1:0]                          O_RESULT_VLD,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]          O_RESULT,
  output logic [NUM_REQ-1:0]                          O_LOAD_W_SIGNAL,
  output logic                                        O_SA_LOAD,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]          O_MAT_1,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]          O_MAT_2,
  output logic                                        O_ACC_SIGNAL,
  input  logic                                        I_SA_VLD,
  input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]          I_SA_RESULT,
  input  logic                                        I_LOAD_W_SIGNAL,
  output logic                                        O_ERR
);

  // state  | meaning
  // IDLE   | no grant; arbitrate among I_REQ from ptr upward
  // LOAD   | grant held; issue the single-cycle O_SA_LOAD pulse
  // WAIT   | waiting for I_SA_VLD from the array
  // DONE   | result delivered; keep grant if locked, else release
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                            state_q;
  logic [NUM_REQ-1:0]                gnt_q;
  logic [NUM_REQ-1:0]                rvld_q;
  logic [IW-1:0]                     gidx_q;
  logic [IW-1:0]                     ptr_q;
  logic [IW-1:0]                     ptr_next;
  logic                              sa_load_q;
  logic                              err_q;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] result_q;
  logic                              pick_vld;
  logic [IW-1:0]                     pick_idx;
  logic [IW-1:0]                     scan_idx;

`ifdef SA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;
`endif

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && I_REQ[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // The releasing requester gets lowest priority next round.
  assign ptr_next = IW'((int'(gidx_q) + 1) % NUM_REQ);

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      rvld_q    <= '0;
      result_q  <= '0;
      sa_load_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SA_ARB_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else begin
      sa_load_q <= 1'b0;
      rvld_q    <= '0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          err_q <= I_SA_VLD;
          if (pick_vld) begin
            gnt_q   <= NUM_REQ'(1) << pick_idx;
            gidx_q  <= pick_idx;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          err_q     <= I_SA_VLD;
          sa_load_q <= 1'b1;
          state_q   <= S_WAIT;
`ifdef SA_ARB_TIMEOUT_EN
          tmr_q     <= TW'(TIMEOUT - 1);
`endif
        end
        S_WAIT: begin
          if (I_SA_VLD) begin
            result_q <= I_SA_RESULT;
            rvld_q   <= gnt_q;
            state_q  <= S_DONE;
          end
`ifdef SA_ARB_TIMEOUT_EN
          else if (tmr_q == '0) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            ptr_q   <= ptr_next;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
`endif
        end
        S_DONE: begin
          err_q <= I_SA_VLD;
          if (I_REQ_LOCK[gidx_q] && I_REQ[gidx_q]) begin
            state_q <= S_LOAD;
          end else begin
            gnt_q   <= '0;
            ptr_q   <= ptr_next;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_MAT_1      = '0;
    O_MAT_2      = '0;
    O_ACC_SIGNAL = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        O_MAT_1      = O_MAT_1 | I_REQ_MAT_1[i];
        O_MAT_2      = O_MAT_2 | I_REQ_MAT_2[i];
        O_ACC_SIGNAL = O_ACC_SIGNAL | I_REQ_ACC[i];
      end
    end
  end

  assign O_GNT           = gnt_q;
  assign O_RESULT_VLD    = rvld_q;
  assign O_RESULT        = result_q;
  assign O_SA_LOAD       = sa_load_q;
  assign O_ERR           = err_q;
  assign O_LOAD_W_SIGNAL = {NUM_REQ{I_LOAD_W_SIGNAL}} & gnt_q;

endmodule

// File: tb/tb_sa_share_arbiter.sv
// Self-checking bench for sa_share_arbiter: directed vector table, corner sequences, and a
// randomized phase checked against a transaction-level round-robin model.
module tb_sa_share_arbiter;

  localparam int N    = 2;
  localparam int D_W  = 8;
  localparam int SA_R = 16;
  localparam int SA_C = 16;
`ifdef SA_ARB_TIMEOUT_EN
  localparam int LONG_LAT = 10;
`else
  localparam int LONG_LAT = 40;
`endif

  typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] mat_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] acc;
    int           lat;
    logic [N-1:0] exp_gnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, lock, acc;
  mat_t [N-1:0]  mat1, mat2;
  logic [N-1:0]  gnt, rvld, lw_out;
  mat_t          result, o_mat1, o_mat2, sa_res;
  logic          sa_load, acc_sig, sa_vld, lw_in, err;

  int checks = 0;
  int errors = 0;
  mat_t last_result;

  sa_share_arbiter #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .NUM_REQ(N), .TIMEOUT(16)) dut (
    .I_CLK(clk), .I_RST_N(rst_n),
    .I_REQ(req), .I_REQ_LOCK(lock), .I_REQ_ACC(acc),
    .I_REQ_MAT_1(mat1), .I_REQ_MAT_2(mat2),
    .O_GNT(gnt), .O_RESULT_VLD(rvld), .O_RESULT(result), .O_LOAD_W_SIGNAL(lw_out),
    .O_SA_LOAD(sa_load), .O_MAT_1(o_mat1), .O_MAT_2(o_mat2), .O_ACC_SIGNAL(acc_sig),
    .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_res), .I_LOAD_W_SIGNAL(lw_in), .O_ERR(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
    int fr, fc;
    checks++;
    if (act !== exp) begin
      errors++;
      fr = 0; fc = 0;
      for (int r = SA_R - 1; r >= 0; r--)
        for (int c = SA_C - 1; c >= 0; c--)
          if (act[r][c] !== exp[r][c]) begin fr = r; fc = c; end
      $display("FAIL %s: element [%0d][%0d] got 0x%0h expected 0x%0h at %0t",
               name, fr, fc, act[fr][fc], exp[fr][fc], $time);
    end
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++)
        m[r][c] = D_W'($urandom);
    return m;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Called on the negedge where the load was seen (array is in WAIT): return a result.
  task automatic complete(input logic [N-1:0] expg);
    mat_t data;
    data   = rand_mat();
    sa_res = data;
    sa_vld = 1'b1;
    tick();
    sa_vld = 1'b0;
    chk("cmp_rvld", rvld, expg);
    chk_mat("cmp_result", result, data);
    last_result = data;
    req  = req & ~expg;
    lock = lock & ~expg;
    tick();
    chk("cmp_release", gnt, '0);
    chk("cmp_rvld_pulse", rvld, '0);
  endtask

  task automatic do_txn(input vec_t v);
    int g, nload;
    g   = onehot_idx(v.exp_gnt);
    req = v.req;
    acc = v.acc;
    tick();
    chk("txn_gnt", gnt, v.exp_gnt);
    chk("txn_load_early", sa_load, 1'b0);
    tick();
    chk("txn_load", sa_load, 1'b1);
    chk("txn_acc", acc_sig, v.acc[g]);
    chk_mat("txn_mat1", o_mat1, mat1[g]);
    chk_mat("txn_mat2", o_mat2, mat2[g]);
    nload = 0;
    for (int k = 0; k < v.lat; k++) begin
      tick();
      if (sa_load) nload++;
    end
    chk("txn_single_load", nload, 0);
    complete(v.exp_gnt);
  endtask

  vec_t        vecs[9];
  int          tiles[N];
  logic        lock_pref[N];
  logic [N-1:0] gnt_m, exp_rvld;
  logic        exp_load, sa_armed, m_idle, fin, rel;
  mat_t        exp_res;
  int          ptr_m, load_in, sa_cnt, g, e_cnt, h_cnt;

  initial begin
    vecs[0] = '{2'b01, 2'b00, LONG_LAT, 2'b01};
    vecs[1] = '{2'b11, 2'b10, 3,        2'b10};
    vecs[2] = '{2'b11, 2'b01, 0,        2'b01};
    vecs[3] = '{2'b11, 2'b00, 5,        2'b10};
    vecs[4] = '{2'b11, 2'b11, 1,        2'b01};
    vecs[5] = '{2'b10, 2'b00, 2,        2'b10};
    vecs[6] = '{2'b10, 2'b10, 4,        2'b10};
    vecs[7] = '{2'b01, 2'b01, 2,        2'b01};
    vecs[8] = '{2'b10, 2'b00, 1,        2'b10};

    rst_n = 1'b0; req = '0; lock = '0; acc = '0; sa_vld = 1'b0; lw_in = 1'b0;
    sa_res = '0; last_result = '0;
    for (int i = 0; i < N; i++) begin mat1[i] = rand_mat(); mat2[i] = rand_mat(); end
    tick(); tick();
    chk("rst_gnt", gnt, '0);
    chk("rst_rvld", rvld, '0);
    chk("rst_load", sa_load, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_acc", acc_sig, 1'b0);
    chk_mat("rst_result", result, '0);
    chk_mat("rst_mat1", o_mat1, '0);
    rst_n = 1'b1;
    tick();

    // Vector table: single request, alternating contention, pointer behaviour.
    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Lock: requester 0 keeps the array for three tiles while requester 1 waits.
    req = 2'b11; lock = 2'b01; acc = 2'b00;
    tick();
    chk("lock_gnt", gnt, 2'b01);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("lock_load", sa_load, 1'b1);
      chk("lock_acc", acc_sig, (t == 0) ? 1'b0 : 1'b1);
      sa_res = rand_mat();
      sa_vld = 1'b1;
      tick();
      sa_vld = 1'b0;
      chk("lock_rvld", rvld, 2'b01);
      chk_mat("lock_result", result, sa_res);
      last_result = sa_res;
      if (t < 2) acc[0] = 1'b1;
      else begin req[0] = 1'b0; lock[0] = 1'b0; end
      tick();
      chk("lock_hold", gnt, (t < 2) ? 2'b01 : 2'b00);
      chk("lock_gap", sa_load, 1'b0);
    end
    tick();
    chk("lock_next_gnt", gnt, 2'b10);
    tick();
    chk("lock_next_load", sa_load, 1'b1);
    complete(2'b10);

    // Spurious I_SA_VLD while idle.
    sa_res = rand_mat();
    sa_vld = 1'b1;
    tick();
    sa_vld = 1'b0;
    chk("spur_err", err, 1'b1);
    chk("spur_rvld", rvld, '0);
    chk_mat("spur_result", result, last_result);
    tick();
    chk("spur_err_pulse", err, 1'b0);

    // Reset during WAIT.
    req = 2'b01; lw_in = 1'b1;
    tick();
    chk("rw_gnt", gnt, 2'b01);
    chk("rw_lw", lw_out, 2'b01);
    tick();
    chk("rw_load", sa_load, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rw_gnt0", gnt, '0);
    chk("rw_rvld0", rvld, '0);
    chk("rw_load0", sa_load, 1'b0);
    chk("rw_acc0", acc_sig, 1'b0);
    chk("rw_err0", err, 1'b0);
    chk("rw_lw0", lw_out, '0);
    chk_mat("rw_result0", result, '0);
    chk_mat("rw_mat1_0", o_mat1, '0);
    chk_mat("rw_mat2_0", o_mat2, '0);
    last_result = '0;
    rst_n = 1'b1; req = '0; lw_in = 1'b0;
    tick();
    sa_res = rand_mat();
    sa_vld = 1'b1;
    tick();
    sa_vld = 1'b0;
    chk("rw_late_err", err, 1'b1);
    chk("rw_late_rvld", rvld, '0);
    chk_mat("rw_late_result", result, '0);
    tick();

    // Array never answers: watchdog release (if built in) or indefinite hold.
    req = 2'b11; e_cnt = 0; h_cnt = 0;
    tick();
    chk("to_gnt", gnt, 2'b01);
    tick();
    chk("to_load", sa_load, 1'b1);
`ifdef SA_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      if (err) e_cnt++;
    end
    chk("to_early_err", e_cnt, 0);
    tick();
    chk("to_err", err, 1'b1);
    chk("to_gnt_drop", gnt, '0);
    chk("to_no_rvld", rvld, '0);
    req = 2'b10;
`else
    for (int k = 0; k < 60; k++) begin
      tick();
      if (err || rvld != '0) e_cnt++;
      if (gnt != 2'b01) h_cnt++;
    end
    chk("hold_no_err", e_cnt, 0);
    chk("hold_gnt", h_cnt, 0);
    complete(2'b01);
`endif
    tick();
    chk("to_other_gnt", gnt, 2'b10);
    tick();
    chk("to_other_load", sa_load, 1'b1);
    complete(2'b10);

    // Randomized traffic against the transaction-level model.
    rst_n = 1'b0; req = '0; lock = '0; sa_vld = 1'b0; lw_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ptr_m = 0; gnt_m = '0; exp_load = 1'b0; exp_rvld = '0; exp_res = '0;
    load_in = 0; sa_armed = 1'b0; sa_cnt = 0; m_idle = 1'b1;
    for (int i = 0; i < N; i++) begin tiles[i] = 0; lock_pref[i] = 1'b0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_gnt", gnt, gnt_m);
      chk("rnd_rvld", rvld, exp_rvld);
      chk("rnd_load", sa_load, exp_load);
      chk("rnd_err", err, 1'b0);
      chk("rnd_lw", lw_out, lw_in ? gnt_m : '0);
      if (exp_rvld != '0) chk_mat("rnd_result", result, exp_res);
      g = onehot_idx(gnt_m);
      if (exp_load) begin
        chk("rnd_acc", acc_sig, acc[g]);
        chk_mat("rnd_mat1", o_mat1, mat1[g]);
        chk_mat("rnd_mat2", o_mat2, mat2[g]);
        sa_armed = 1'b1;
        sa_cnt   = $urandom_range(0, 5);
      end
      fin = (exp_rvld != '0);
      sa_vld   = 1'b0;
      exp_rvld = '0;
      if (sa_armed) begin
        if (sa_cnt == 0) begin
          sa_res   = rand_mat();
          exp_res  = sa_res;
          sa_vld   = 1'b1;
          exp_rvld = gnt_m;
          sa_armed = 1'b0;
        end else sa_cnt--;
      end
      rel = 1'b0;
      if (fin) begin
        tiles[g]--;
        acc[g]  = 1'($urandom);
        mat1[g] = rand_mat();
        mat2[g] = rand_mat();
        if (tiles[g] > 0 && lock_pref[g]) load_in = 2;
        else begin
          gnt_m  = '0;
          ptr_m  = (g + 1) % N;
          m_idle = 1'b1;
          rel    = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!(fin && i == g) && tiles[i] == 0 && $urandom_range(0, 3) == 0) begin
          tiles[i]     = $urandom_range(1, 3);
          lock_pref[i] = 1'($urandom_range(0, 1));
        end
        req[i]  = (tiles[i] > 0);
        lock[i] = (tiles[i] > 0) && lock_pref[i];
      end
      if (m_idle && !rel && req != '0) begin
        gnt_m   = N'(1) << rr_pick(req, ptr_m);
        load_in = 2;
        m_idle  = 1'b0;
      end
      exp_load = (load_in == 1);
      if (load_in > 0) load_in--;
      lw_in = 1'($urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
